// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and byte width for the ALU and its word sequencer.
// Pure definitions: no latency, no flow control.
package alu_pkg;
  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    kADD = 3'd0,
    kLSH = 3'd1,
    kRSH = 3'd2,
    kXOR = 3'd3,
    kAND = 3'd4,
    kSUB = 3'd5
  } op_mne;
endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with a single carry/shift bit in and out.
// Zero latency; no flow control.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_sc_in,
  output logic [ALU_W-1:0] o_out,
  output logic             o_sc_out
);
  always_comb begin
    o_out    = '0;
    o_sc_out = 1'b0;
    case (i_op)
      kADD: {o_sc_out, o_out} = {1'b0, i_a} + {1'b0, i_b} + {{ALU_W{1'b0}}, i_sc_in};
      kLSH: {o_sc_out, o_out} = {i_a, i_sc_in};
      kRSH: {o_out, o_sc_out} = {i_sc_in, i_a};
      kXOR: o_out = i_a ^ i_b;
      kAND: o_out = i_a & i_b;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_word_sequencer.sv
// Runs an NBYTES-wide op through the byte ALU one lane per cycle, threading carry/shift bits.
// Latency NBYTES+1 cycles START->DONE; START is ignored while busy, accepted in IDLE or DONE.
module alu_word_sequencer
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic [2:0]              i_op,
  input  logic [ALU_W*NBYTES-1:0] i_word_a,
  input  logic [ALU_W*NBYTES-1:0] i_word_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ALU_W*NBYTES-1:0] o_result,
  output logic                    o_carry,
  output logic                    o_zero,
  output logic [ALU_W-1:0]        o_alu_a,
  output logic [ALU_W-1:0]        o_alu_b,
  output logic [2:0]              o_alu_op_out,
  output logic                    o_alu_sc_in,
  input  logic [ALU_W-1:0]        i_alu_result,
  input  logic                    i_alu_sc_out
);
  localparam int         W    = ALU_W * NBYTES;
  localparam logic [1:0] LAST = 2'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [W-1:0]     r_a, r_b, r_result;
  logic [1:0]       r_idx;
  logic             r_carry;
  logic             r_have;
  logic             w_accept, w_legal;
  logic [1:0]       w_lane;
  logic [ALU_W-1:0] w_byte_a, w_byte_b;

  assign w_accept = i_start && (r_state != RUN);
  assign w_legal  = (r_op <= kSUB);
  // Right shifts walk from the top lane down so the shift-out bit feeds the next lower byte.
  assign w_lane   = (r_op == kRSH) ? (LAST - r_idx) : r_idx;

  always_comb begin
    w_byte_a = '0;
    w_byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_lane == 2'(i)) begin
        w_byte_a = r_a[i*ALU_W +: ALU_W];
        w_byte_b = r_b[i*ALU_W +: ALU_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_idx == LAST) w_next = DONE;
      DONE:    w_next = i_start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_op_out = kADD;
    o_alu_sc_in  = 1'b0;
    if (r_state == RUN && w_legal) begin
      o_alu_a      = w_byte_a;
      o_alu_b      = (r_op == kSUB) ? ~w_byte_b : w_byte_b;
      o_alu_op_out = (r_op == kSUB) ? kADD : r_op;
      o_alu_sc_in  = r_carry;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_op     <= kADD;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_have   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= i_op;
        r_a      <= i_word_a;
        r_b      <= i_word_b;
        r_result <= '0;
        r_idx    <= '0;
        // Subtract is A + ~B + 1, so the first byte gets the +1 as carry-in.
        r_carry  <= (i_op == kSUB);
        r_have   <= 1'b0;
      end else if (r_state == RUN) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (w_lane == 2'(i)) r_result[i*ALU_W +: ALU_W] <= w_legal ? i_alu_result : '0;
        end
        r_carry <= w_legal && i_alu_sc_out;
        r_idx   <= r_idx + 2'd1;
        if (r_idx == LAST) r_have <= 1'b1;
      end
    end
  end

  assign o_busy   = (r_state == RUN);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;
  assign o_carry  = r_carry && (r_op == kADD || r_op == kSUB || r_op == kLSH || r_op == kRSH);
  // ZERO stays low until a result has actually been produced, so reset reads as all zeros.
  assign o_zero   = r_have && ~|r_result;
endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer (NBYTES=2) driving the real byte ALU.
// Expected words come from a whole-word reference model queued at START time.
module tb_alu_word_sequencer;
  import alu_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] word_a, word_b;
  logic         busy, done, carry, zero;
  logic [W-1:0] result;
  logic [7:0]   alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_sc_in, alu_sc_out;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   lat, nbusy, nd;
  logic [7:0] f_a, f_b;
  logic [2:0] f_op;

  alu_word_sequencer #(.NBYTES(NB)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
    .i_word_a(word_a), .i_word_b(word_b),
    .o_busy(busy), .o_done(done), .o_result(result), .o_carry(carry), .o_zero(zero),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op_out(alu_op), .o_alu_sc_in(alu_sc_in),
    .i_alu_result(alu_res), .i_alu_sc_out(alu_sc_out)
  );

  alu u_alu (
    .i_a(alu_a), .i_b(alu_b), .i_op(alu_op), .i_sc_in(alu_sc_in),
    .o_out(alu_res), .o_sc_out(alu_sc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Whole-word reference: returns {carry, result}.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {a, 1'b0};
      3'd2:    return {a[0], 1'b0, a[W-1:1]};
      3'd3:    return {1'b0, a ^ b};
      3'd4:    return {1'b0, a & b};
      3'd5:    return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      default: return '0;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    logic [W:0] m;
    exp_t e;
    m   = model(o, a, b);
    e.r = m[W-1:0];
    e.c = (o == 3'd3 || o == 3'd4) ? 1'b0 : m[W];
    e.z = (m[W-1:0] == '0);
    op = o; word_a = a; word_b = b; start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    op     = 3'($urandom);
    word_a = W'($urandom);
    word_b = W'($urandom);
  endtask

  task automatic wait_done(output int l, output int nb);
    l = 0; nb = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        f_a = alu_a; f_b = alu_b; f_op = alu_op;
      end
      if (busy) nb++;
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {16'b0, result}, {16'b0, mon_e.r});
        chk("carry",  {31'b0, carry},  {31'b0, mon_e.c});
        chk("zero",   {31'b0, zero},   {31'b0, mon_e.z});
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; word_a = '0; word_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, busy},   0);
    chk("rst_done",   {31'b0, done},   0);
    chk("rst_result", {16'b0, result}, 0);
    chk("rst_carry",  {31'b0, carry},  0);
    chk("rst_zero",   {31'b0, zero},   0);
    chk("rst_alu",    {11'b0, alu_a, alu_b, alu_op, alu_sc_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with cross-byte carry, latency and busy width
    start_op(3'd0, 16'h00FF, 16'h0001, 1);
    wait_done(lat, nbusy);
    chk("add_latency", lat, 3);
    chk("add_busy_cycles", nbusy, 2);
    @(negedge clk);
    chk("idle_after_done", {30'b0, busy, done}, 0);

    // SUB without and with borrow
    start_op(3'd5, 16'h1000, 16'h0001, 1);
    wait_done(lat, nbusy);
    chk("sub_latency", lat, 3);
    chk("sub_alu_op", {29'b0, f_op}, 0);
    chk("sub_alu_b_inv", {24'b0, f_b}, 32'h0000_00FE);
    @(negedge clk);
    start_op(3'd5, 16'h0001, 16'h0002, 1);
    wait_done(lat, nbusy);
    @(negedge clk);

    // Shifts; RSH must present the MSB byte first
    start_op(3'd1, 16'h8080, 16'h0000, 1);
    wait_done(lat, nbusy);
    @(negedge clk);
    start_op(3'd2, 16'h0101, 16'h0000, 1);
    wait_done(lat, nbusy);
    chk("rsh_first_alu_a", {24'b0, f_a}, 32'h01);
    chk("rsh_first_alu_op", {29'b0, f_op}, 2);
    @(negedge clk);

    // XOR to zero, AND, illegal op
    start_op(3'd3, 16'hA5A5, 16'hA5A5, 1);
    wait_done(lat, nbusy);
    @(negedge clk);
    start_op(3'd4, 16'hF0CC, 16'h3C0F, 1);
    wait_done(lat, nbusy);
    @(negedge clk);
    start_op(3'd7, 16'h1234, 16'h5678, 1);
    wait_done(lat, nbusy);
    chk("illegal_latency", lat, 3);
    chk("illegal_alu_idle", {13'b0, f_a, f_b, f_op}, 0);
    @(negedge clk);

    // START during RUN is ignored
    start_op(3'd0, 16'h1234, 16'h1111, 1);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; word_a = 16'hFFFF; word_b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ign_done", {31'b0, done}, 1);
    nd = 0; nbusy = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nbusy++;
    end
    chk("ign_no_rerun_done", nd, 0);
    chk("ign_no_rerun_busy", nbusy, 0);

    // Back-to-back: START held in the DONE cycle
    start_op(3'd0, 16'h0001, 16'h0002, 1);
    wait_done(lat, nbusy);
    chk("b2b_first_latency", lat, 3);
    start_op(3'd3, 16'hF0F0, 16'h0FF0, 1);
    wait_done(lat, nbusy);
    chk("b2b_second_latency", lat, 3);
    chk("b2b_no_gap_busy", nbusy, 2);
    @(negedge clk);

    // Reset during the first RUN cycle aborts
    start_op(3'd0, 16'hFFFF, 16'h0001, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {13'b0, busy, done, carry, zero, result}, 0);
    chk("abort_alu", {11'b0, alu_a, alu_b, alu_op, alu_sc_in}, 0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    nbusy = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nbusy++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_stays_idle", nbusy, 0);
    start_op(3'd0, 16'h0102, 16'h0304, 1);
    wait_done(lat, nbusy);
    chk("post_abort_latency", lat, 3);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-byte front end for the 8-bit ALU. It accepts one NBYTES-wide operation per START and drives the combinational ALU one byte per cycle, threading the carry or shift bit between bytes through a register. It collects the result bytes and returns the full word with CARRY, ZERO and a one-cycle DONE pulse. It sits between the register-file/decode stage and the ALU, directly feeding the ALU's INPUT_A/INPUT_B/ALU_OP/SC_IN and consuming its OUTPUT/SC_OUT.

## Interface
- NBYTES, default 2: bytes per word; legal values are 2 to 4.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request strobe. It is sampled only in state IDLE or DONE.
- OP  in  3  operation, of type op_mne.
- WORD_A, WORD_B  in  8*NBYTES  operands. They are captured on the START edge.
- BUSY  out  1  high while the sequencer is in RUN.
- DONE  out  1  one-cycle pulse; RESULT, CARRY and ZERO are valid in that cycle.
- RESULT  out  8*NBYTES  final word. It holds until the next accepted START or reset.
- CARRY  out  1  final carry or shift-out bit.
- ZERO  out  1  high when RESULT is 0.
- ALU_A, ALU_B  out  8  byte operands to the ALU.
- ALU_OP_OUT  out  3  ALU opcode.
- ALU_SC_IN  out  1  carry-in or shift-in to the ALU.
- ALU_RESULT  in  8  ALU OUTPUT.
- ALU_SC_OUT  in  1  ALU SC_OUT.

## Operation
- Opcode encodings: kADD=0, kLSH=1, kRSH=2, kXOR=3, kAND=4, kSUB=5. Codes 6 and 7 are illegal.
- ALU contract the sequencer relies on:
  - kADD: {SC_OUT,OUT} = A + B + SC_IN.
  - kLSH: {SC_OUT,OUT} = {A,SC_IN}.
  - kRSH: {OUT,SC_OUT} = {SC_IN,A}.
  - kXOR and kAND: bitwise; SC_OUT is ignored.
- FSM states and transitions:
  - IDLE: START moves to RUN.
  - RUN: stays for exactly NBYTES cycles, then moves to DONE.
  - DONE: moves to IDLE, or to RUN if START is high.
- On an accepted START, the sequencer:
  - latches OP, WORD_A and WORD_B;
  - sets the byte index to 0;
  - loads the carry register with the initial value: 1 for kSUB, 0 for all other ops;
  - clears RESULT.
- Byte order:
  - kRSH processes the MSB byte first.
  - All other ops process the LSB byte first.
  - The index counts 0 to NBYTES-1 and maps to byte lanes according to this order.
- ALU drive in RUN, combinational from registers:
  - ALU_A is the current byte of A.
  - ALU_B is the current byte of B, except for kSUB, which drives ~B byte.
  - ALU_OP_OUT is OP, except for kSUB, which drives kADD.
  - ALU_SC_IN is the carry register.
- Each RUN edge:
  - the current RESULT lane takes ALU_RESULT;
  - the carry register takes ALU_SC_OUT;
  - the index increments.
- CARRY:
  - equals the carry register for ADD, SUB, LSH and RSH;
  - is forced to 0 for XOR and AND;
  - for kSUB, CARRY=1 means no borrow.
- ZERO is computed as the reduction NOR of the registered RESULT.
- Illegal OP: the sequencer still runs NBYTES cycles and ALU drive stays at its idle values. It then finishes with RESULT=0, CARRY=0, ZERO=1.
- Outside RUN, ALU drive is ALU_A=0, ALU_B=0, ALU_OP_OUT=kADD, ALU_SC_IN=0.

## Timing
- Reset values: state IDLE; BUSY, DONE, RESULT, CARRY and ZERO are all 0; index 0; ALU drive at its idle values.
- Latency: START is sampled at edge k. BUSY is high in cycles k+1 to k+NBYTES. DONE is high in cycle k+NBYTES+1 only.
- Throughput: back-to-back operation is allowed. A START high during the DONE cycle is accepted, giving one result every NBYTES+1 cycles.
- START while BUSY is ignored. It is not queued and operands are not re-captured.
- Operand inputs may change freely after the START edge.
- Reset asserted mid-RUN aborts the operation immediately: no DONE and outputs at reset values. After reset, the sequencer waits for a fresh START.
- The ALU is combinational; each byte step uses exactly one cycle.

## Structure
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] op_mne, with kADD through kSUB at the values above;
  - constant ALU_W = 8.
- The ALU uses the same package.
- The FSM state enum is local to this module.
- Single module; no sub-module is needed. Instantiate it with the ALU in the bench.

## Test plan
1. NBYTES=2, kADD 0x00FF + 0x0001 -> RESULT=0x0100, CARRY=0, ZERO=0. DONE arrives exactly 3 cycles after the START edge and BUSY is high for 2 cycles.
2. kSUB 0x1000 - 0x0001 -> 0x0FFF, CARRY=1. Then kSUB 0x0001 - 0x0002 -> 0xFFFF, CARRY=0.
3. Shifts:
   - kLSH A=0x8080 -> 0x0100, CARRY=1.
   - kRSH A=0x0101 -> 0x0080, CARRY=1; ALU_A must show 0x01 (MSB byte) in the first RUN cycle.
4. kXOR 0xA5A5 ^ 0xA5A5 -> 0x0000, ZERO=1, CARRY=0. Illegal OP=7 -> RESULT=0, ZERO=1.
5. Handshake:
   - START pulsed in the second RUN cycle with new operands is ignored, and the original result is returned.
   - START held high in the DONE cycle starts the next op with no idle gap.
6. RESET_N low during the first RUN cycle of kADD 0xFFFF + 0x0001 -> all outputs 0, no DONE pulse, state IDLE. The next START completes normally.
